// File: rtl/hypercpu_mem_pkg.sv
// hypercpu_mem_pkg: shared constants for the hypercpu memory bus and its MMIO map.
package hypercpu_mem_pkg;
    localparam logic [31:0] ADDR_CONSOLE = 32'hFFFF_FF00;
    localparam logic [31:0] ADDR_STATUS  = 32'hFFFF_FF01;
    localparam logic [31:0] ADDR_CYCLES  = 32'hFFFF_FF02;
    localparam logic [31:0] ADDR_HALT    = 32'hFFFF_FF03;
    localparam int STATUS_NONEMPTY  = 0;
    localparam int STATUS_FULL      = 1;
    localparam int STATUS_OVERFLOW  = 2;
    localparam int STATUS_COUNT_LSB = 4;
    localparam logic MCLK_MEM_INSTRUCTION = 1'b0;
    localparam logic MCLK_MEM_LOADSTORE   = 1'b1;
endpackage

// File: rtl/hypercpu_fifo.sv
// hypercpu_fifo: small synchronous FIFO; a push into a full FIFO is accepted only alongside a pop.
module hypercpu_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic do_push, do_pop;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    assign dout    = mem[rd_ptr];
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/hypercpu_memory.sv
// hypercpu_memory: RAM plus console/cycle/halt MMIO answering the hypercpu bus.
// All state advances on the falling mclk edge, closing the load/store phase.
module hypercpu_memory
    import hypercpu_mem_pkg::*;
#(
    parameter int    ADDR_BITS  = 12,
    parameter string INIT_FILE  = "",
    parameter int    FIFO_DEPTH = 4
) (
    input  logic        mclk,
    input  logic        reset,
    input  logic [31:0] mem_addr,
    inout  tri   [31:0] mem_read,
    input  logic [31:0] mem_write,
    input  logic        mem_write_enable,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        halt,
    output logic [7:0]  halt_code
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    logic [31:0] ram [2**ADDR_BITS];
    logic [31:0] cycles, rd_data;
    logic [7:0] status;
    logic [CW-1:0] count;
    logic overflow, full, empty, in_ram, push, pop, mclk_n;
    assign mclk_n   = ~mclk;
    assign in_ram   = mem_addr[31:ADDR_BITS] == '0;
    assign push     = mem_write_enable && mem_addr == ADDR_CONSOLE;
    assign tx_valid = !empty;
    assign pop      = tx_valid && tx_ready;
    assign mem_read = rd_data;
    always_comb begin
        status = '0;
        status[STATUS_NONEMPTY] = !empty;
        status[STATUS_FULL] = full;
        status[STATUS_OVERFLOW] = overflow;
        status[STATUS_COUNT_LSB +: 4] = 4'(count);
    end
    always_comb
        rd_data = in_ram                  ? ram[mem_addr[ADDR_BITS-1:0]] :
                  mem_addr == ADDR_STATUS ? {24'b0, status} :
                  mem_addr == ADDR_CYCLES ? cycles :
                  mem_addr == ADDR_HALT   ? {23'b0, halt, halt_code} : '0;
    // RAM sits outside the reset domain so stores commit even while reset is held
    always_ff @(negedge mclk)
        if (mem_write_enable && in_ram) ram[mem_addr[ADDR_BITS-1:0]] <= mem_write;
    always_ff @(negedge mclk) begin
        if (reset) begin
            cycles    <= '0;
            overflow  <= 1'b0;
            halt      <= 1'b0;
            halt_code <= '0;
        end else begin
            cycles <= (mem_write_enable && mem_addr == ADDR_CYCLES) ? mem_write : cycles + 1'b1;
            if (push && full && !pop) overflow <= 1'b1;
            else if (mem_write_enable && mem_addr == ADDR_STATUS) overflow <= 1'b0;
            if (mem_write_enable && mem_addr == ADDR_HALT) begin
                halt      <= 1'b1;
                halt_code <= mem_write[7:0];
            end
        end
    end
    hypercpu_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(mclk_n),
        .rst(reset),
        .push(push),
        .pop(pop),
        .din(mem_write[7:0]),
        .dout(tx_data),
        .full(full),
        .empty(empty),
        .count(count)
    );
endmodule
